stim_controller: RTL and testbench

- Closed-loop stimulation controller directly downstream of neurondetect.
- Consumes the per-sample seizure flag and debounces it over consecutive samples.
- On a confirmed detection, emits a charge-balanced biphasic pulse train, then enforces a refractory period.
- Drives the stimulation outputs that the system bench monitors.

---
 rtl/stim_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_stim_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_controller.sv
// ---------------------------------------------------------------------------
// stim_controller
// Closed-loop stimulation controller fed by the neurondetect seizure flag.
// Debounces the per-sample flag over CONFIRM_COUNT consecutive enabled
// cycles. It then emits a charge-balanced biphasic pulse train of NUM_PULSES
// pulses, followed by a REFRACTORY hold-off. Once phase A has started, the
// train always runs to completion; only rst can abort it.
//
// Optional feature (macro STIM_RETRIGGER_EN):
//   When defined, en=1 and seizure=1 on the final refractory cycle start a
//   new train directly, skipping the IDLE and CONFIRM states.
//   When undefined, the controller always returns to IDLE and must confirm
//   again.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           detector enable (same signal as neurondetect en)
//   seizure      detection flag from neurondetect, sampled every clk
//   stim_pos     phase A (cathodic) drive, registered
//   stim_neg     phase B (anodic) drive, registered
//   stim_active  high from first phase-A cycle to last phase-B cycle of a train
//   refractory   high during the refractory hold-off
//   stim_count   number of delivered trains, saturating
// ---------------------------------------------------------------------------
module stim_controller #(
    parameter int unsigned CONFIRM_COUNT  = 4,
    parameter int unsigned PULSE_WIDTH    = 8,
    parameter int unsigned INTERPHASE_GAP = 2,
    parameter int unsigned PULSE_PERIOD   = 32,
    parameter int unsigned NUM_PULSES     = 4,
    parameter int unsigned REFRACTORY     = 64,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 seizure,
    output logic                 stim_pos,
    output logic                 stim_neg,
    output logic                 stim_active,
    output logic                 refractory,
    output logic [CNT_WIDTH-1:0] stim_count
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned BURST_LEN = 2 * PULSE_WIDTH + INTERPHASE_GAP;
    localparam int unsigned REST_LEN  = (PULSE_PERIOD >= BURST_LEN) ? (PULSE_PERIOD - BURST_LEN) : 0;

    // One phase counter covers every timed state, so it is sized for the longest one.
    localparam int unsigned PH_MAX = max2(max2(CONFIRM_COUNT, PULSE_WIDTH),
                                          max2(max2(INTERPHASE_GAP, REST_LEN), REFRACTORY));
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned PN_W   = $clog2(NUM_PULSES + 1);

    // Parameter legality checks at elaboration.
    if (PULSE_PERIOD < BURST_LEN) begin : g_bad_period
        $error("stim_controller: PULSE_PERIOD must be >= 2*PULSE_WIDTH+INTERPHASE_GAP");
    end
    if (CONFIRM_COUNT < 1 || PULSE_WIDTH < 1 || NUM_PULSES < 1 || REFRACTORY < 1) begin : g_bad_min
        $error("stim_controller: CONFIRM_COUNT, PULSE_WIDTH, NUM_PULSES and REFRACTORY must be >= 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("stim_controller: CNT_WIDTH must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONFIRM = 3'd1,
        PHASE_A = 3'd2,
        GAP     = 3'd3,
        PHASE_B = 3'd4,
        REST    = 3'd5,
        REFRACT = 3'd6
    } state_t;

    state_t          state;
    logic [PH_W-1:0] phase_cnt;   // 1-based cycle index within the current state
    logic [PN_W-1:0] pulse_cnt;   // 1-based index of the pulse in progress

    // FSM with registered outputs; each transition sets the outputs of the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            pulse_cnt   <= '0;
            stim_pos    <= 1'b0;
            stim_neg    <= 1'b0;
            stim_active <= 1'b0;
            refractory  <= 1'b0;
            stim_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && seizure) begin
                        phase_cnt <= PH_W'(1);
                        if (CONFIRM_COUNT == 1) begin
                            state       <= PHASE_A;
                            pulse_cnt   <= PN_W'(1);
                            stim_pos    <= 1'b1;
                            stim_active <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end

                CONFIRM: begin
                    if (en && seizure) begin
                        if (phase_cnt == PH_W'(CONFIRM_COUNT - 1)) begin
                            state       <= PHASE_A;
                            phase_cnt   <= PH_W'(1);
                            pulse_cnt   <= PN_W'(1);
                            stim_pos    <= 1'b1;
                            stim_active <= 1'b1;
                        end else begin
                            phase_cnt <= phase_cnt + PH_W'(1);
                        end
                    end else begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                    end
                end

                PHASE_A: begin
                    if (phase_cnt == PH_W'(PULSE_WIDTH)) begin
                        stim_pos  <= 1'b0;
                        phase_cnt <= PH_W'(1);
                        if (INTERPHASE_GAP == 0) begin
                            state    <= PHASE_B;
                            stim_neg <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                GAP: begin
                    if (phase_cnt == PH_W'(INTERPHASE_GAP)) begin
                        state     <= PHASE_B;
                        phase_cnt <= PH_W'(1);
                        stim_neg  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                PHASE_B: begin
                    if (phase_cnt == PH_W'(PULSE_WIDTH)) begin
                        stim_neg  <= 1'b0;
                        phase_cnt <= PH_W'(1);
                        if (pulse_cnt == PN_W'(NUM_PULSES)) begin
                            // Train delivered: count it and start the hold-off.
                            state       <= REFRACT;
                            stim_active <= 1'b0;
                            refractory  <= 1'b1;
                            if (stim_count != '1) begin
                                stim_count <= stim_count + CNT_WIDTH'(1);
                            end
                        end else if (REST_LEN == 0) begin
                            state     <= PHASE_A;
                            pulse_cnt <= pulse_cnt + PN_W'(1);
                            stim_pos  <= 1'b1;
                        end else begin
                            state <= REST;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                REST: begin
                    if (phase_cnt == PH_W'(REST_LEN)) begin
                        state     <= PHASE_A;
                        phase_cnt <= PH_W'(1);
                        pulse_cnt <= pulse_cnt + PN_W'(1);
                        stim_pos  <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                REFRACT: begin
                    if (phase_cnt == PH_W'(REFRACTORY)) begin
                        refractory <= 1'b0;
`ifdef STIM_RETRIGGER_EN
                        if (en && seizure) begin
                            state       <= PHASE_A;
                            phase_cnt   <= PH_W'(1);
                            pulse_cnt   <= PN_W'(1);
                            stim_pos    <= 1'b1;
                            stim_active <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            phase_cnt <= '0;
                        end
`else
                        state     <= IDLE;
                        phase_cnt <= '0;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end

                default: begin
                    state       <= IDLE;
                    phase_cnt   <= '0;
                    pulse_cnt   <= '0;
                    stim_pos    <= 1'b0;
                    stim_neg    <= 1'b0;
                    stim_active <= 1'b0;
                    refractory  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_controller.sv
// ---------------------------------------------------------------------------
// tb_stim_controller
// Directed self-checking bench for stim_controller. Expected waveforms come
// from a closed-form train timing model: pulse starts every PER cycles, with
// phase A, gap, phase B and refractory windows. Two instances are used:
// dut runs with the default parameters, and dut2 uses CNT_WIDTH=2 and
// REFRACTORY=4 for the saturation scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stim_controller;

    localparam int W     = 8;
    localparam int G     = 2;
    localparam int PER   = 32;
    localparam int TRAIN = 3 * PER + 2 * W + G;   // 114
    localparam int REFR  = 64;
    localparam int REFR2 = 4;
`ifdef STIM_RETRIGGER_EN
    localparam int GAP2 = 0;    // REFRACT exits straight into PHASE_A
`else
    localparam int GAP2 = 4;    // IDLE cycle + 3 further confirm edges
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, seizure = 1'b0;
    logic stim_pos, stim_neg, stim_active, refractory;
    logic [15:0] stim_count;
    logic rst2 = 1'b1, en2 = 1'b0, seizure2 = 1'b0;
    logic stim_pos2, stim_neg2, stim_active2, refractory2;
    logic [1:0] stim_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stim_controller dut (
        .clk(clk), .rst(rst), .en(en), .seizure(seizure),
        .stim_pos(stim_pos), .stim_neg(stim_neg), .stim_active(stim_active),
        .refractory(refractory), .stim_count(stim_count)
    );

    stim_controller #(.CNT_WIDTH(2), .REFRACTORY(REFR2)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .seizure(seizure2),
        .stim_pos(stim_pos2), .stim_neg(stim_neg2), .stim_active(stim_active2),
        .refractory(refractory2), .stim_count(stim_count2)
    );

    // Expected {pos,neg,active,refractory} at cycle i for a train whose first phase-A cycle is t0.
    function automatic logic [3:0] exp_vec(input int i, input int t0);
        logic [3:0] v;
        int d;
        int p;
        v = 4'b0000;
        d = i - t0;
        if (d >= 0 && d < TRAIN) begin
            p = d % PER;
            v[1] = 1'b1;
            if (p < W) v[3] = 1'b1;
            else if (p >= W + G && p < 2 * W + G) v[2] = 1'b1;
        end else if (d >= TRAIN && d < TRAIN + REFR) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; en = 1'b1; seizure = 1'b1;
        step(); step();
        rst = 1'b0; rst2 = 1'b0; en = 1'b0; seizure = 1'b0;
        checks++;
        if ({stim_pos, stim_neg, stim_active, refractory} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b exp 0000", {stim_pos, stim_neg, stim_active, refractory});
        end
        checks++;
        if (stim_count !== 16'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", stim_count);
        end
        checks++;
        if ({stim_pos2, stim_neg2, stim_active2, refractory2} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs2 got %b exp 0000", {stim_pos2, stim_neg2, stim_active2, refractory2});
        end
        checks++;
        if (stim_count2 !== 2'd0) begin
            errors++; $display("FAIL reset_count2 got %0d exp 0", stim_count2);
        end
    endtask

    // Three highs then low must not trigger; a fresh run then needs full confirmation.
    task automatic test_debounce();
        do_reset();
        en = 1'b1; seizure = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 2) seizure = 1'b0;
            checks++;
            if ({stim_pos, stim_neg, stim_active, refractory} !== 4'b0000) begin
                errors++; $display("FAIL debounce_quiet c=%0d got %b exp 0000", c, {stim_pos, stim_neg, stim_active, refractory});
            end
        end
        checks++;
        if (stim_count !== 16'd0) begin
            errors++; $display("FAIL debounce_count got %0d exp 0", stim_count);
        end
        seizure = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (stim_pos !== (c == 3)) begin
                errors++; $display("FAIL debounce_latency c=%0d stim_pos got %b exp %b", c, stim_pos, (c == 3));
            end
        end
        seizure = 1'b0;
        do_reset();
    endtask

    // Full first train with seizure held high; cycle c counts edges from the first sample.
    task automatic test_single_train();
        do_reset();
        en = 1'b1; seizure = 1'b1;
        for (int c = 0; c <= 3 + TRAIN + REFR - 1; c++) begin
            step();
            checks++;
            if ({stim_pos, stim_neg, stim_active, refractory} !== exp_vec(c, 3)) begin
                errors++; $display("FAIL train1_wave c=%0d got %b exp %b", c, {stim_pos, stim_neg, stim_active, refractory}, exp_vec(c, 3));
            end
            checks++;
            if (stim_pos && stim_neg) begin
                errors++; $display("FAIL train1_overlap c=%0d pos=%b neg=%b exp not both 1", c, stim_pos, stim_neg);
            end
            checks++;
            if (stim_count !== ((c >= 3 + TRAIN) ? 16'd1 : 16'd0)) begin
                errors++; $display("FAIL train1_count c=%0d got %0d exp %0d", c, stim_count, (c >= 3 + TRAIN) ? 1 : 0);
            end
        end
    endtask

    // Continues from test_single_train with seizure still high: second train.
    task automatic test_rearm();
        int t0;
        t0 = 3 + TRAIN + REFR + GAP2;
        for (int c = 3 + TRAIN + REFR; c <= t0 + TRAIN + 3; c++) begin
            step();
            checks++;
            if ({stim_pos, stim_neg, stim_active, refractory} !== exp_vec(c, t0)) begin
                errors++; $display("FAIL train2_wave c=%0d got %b exp %b", c, {stim_pos, stim_neg, stim_active, refractory}, exp_vec(c, t0));
            end
            checks++;
            if (stim_count !== ((c >= t0 + TRAIN) ? 16'd2 : 16'd1)) begin
                errors++; $display("FAIL train2_count c=%0d got %0d exp %0d", c, stim_count, (c >= t0 + TRAIN) ? 2 : 1);
            end
        end
    endtask

    // Reset in the third cycle of phase A aborts the train and clears the count.
    task automatic test_reset_abort();
        for (int i = 0; i < 200 && !stim_pos; i++) step();
        checks++;
        if (stim_pos !== 1'b1) begin
            errors++; $display("FAIL abort_wait_pos timeout stim_pos got %b exp 1", stim_pos);
        end
        checks++;
        if (stim_count !== 16'd2) begin
            errors++; $display("FAIL abort_precount got %0d exp 2", stim_count);
        end
        step(); step();
        checks++;
        if ({stim_pos, stim_active} !== 2'b11) begin
            errors++; $display("FAIL abort_phase_a3 got %b exp 11", {stim_pos, stim_active});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({stim_pos, stim_neg, stim_active, refractory} !== 4'b0000) begin
            errors++; $display("FAIL abort_outputs got %b exp 0000", {stim_pos, stim_neg, stim_active, refractory});
        end
        checks++;
        if (stim_count !== 16'd0) begin
            errors++; $display("FAIL abort_count got %0d exp 0", stim_count);
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if ({stim_pos, stim_neg, stim_active, refractory} !== exp_vec(c, 4)) begin
                errors++; $display("FAIL abort_reconfirm c=%0d got %b exp %b", c, {stim_pos, stim_neg, stim_active, refractory}, exp_vec(c, 4));
            end
        end
    endtask

    // en dropped during CONFIRM restarts confirmation; dropped mid-train changes nothing.
    task automatic test_en_drop();
        do_reset();
        en = 1'b1; seizure = 1'b1;
        for (int c = 0; c <= 6 + TRAIN + REFR - 1; c++) begin
            step();
            checks++;
            if ({stim_pos, stim_neg, stim_active, refractory} !== exp_vec(c, 6)) begin
                errors++; $display("FAIL endrop_wave c=%0d got %b exp %b", c, {stim_pos, stim_neg, stim_active, refractory}, exp_vec(c, 6));
            end
            checks++;
            if (stim_count !== ((c >= 6 + TRAIN) ? 16'd1 : 16'd0)) begin
                errors++; $display("FAIL endrop_count c=%0d got %0d exp %0d", c, stim_count, (c >= 6 + TRAIN) ? 1 : 0);
            end
            if (c == 1 || c == 9) en = 1'b0;
            if (c == 2 || c == 10) en = 1'b1;
        end
        seizure = 1'b0;
        do_reset();
    endtask

    // Two-bit counter on dut2 must saturate at 3.
    task automatic test_saturation();
        int c;
        int per2;
        per2 = TRAIN + REFR2 + GAP2;
        rst2 = 1'b1; step(); rst2 = 1'b0;
        en2 = 1'b1; seizure2 = 1'b1;
        c = -1;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 300; i++) begin
                step(); c++;
                if (refractory2) break;
            end
            checks++;
            if (c !== 3 + n * per2 + TRAIN) begin
                errors++; $display("FAIL sat_refract_start n=%0d cycle got %0d exp %0d", n, c, 3 + n * per2 + TRAIN);
            end
            checks++;
            if (stim_count2 !== ((n < 3) ? 2'(n + 1) : 2'd3)) begin
                errors++; $display("FAIL sat_count n=%0d got %0d exp %0d", n, stim_count2, (n < 3) ? n + 1 : 3);
            end
            for (int i = 0; i < REFR2; i++) begin
                step(); c++;
            end
        end
        en2 = 1'b0; seizure2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_single_train();
        test_rearm();
        test_reset_abort();
        test_en_drop();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
